// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, latency
// defaults and the op classifiers used by both the MDU and the decoder.
package mdu_pkg;

    typedef enum logic [2:0] {
        MDU_MULT  = 3'd0,
        MDU_MULTU = 3'd1,
        MDU_DIV   = 3'd2,
        MDU_DIVU  = 3'd3,
        MDU_MTHI  = 3'd4,
        MDU_MTLO  = 3'd5
    } mdu_op_e;

    localparam int DEF_WIDTH       = 32;
    localparam int DEF_MULT_CYCLES = 5;
    localparam int DEF_DIV_CYCLES  = 10;

    function automatic logic is_multicycle(input logic [2:0] op);
        return op inside {MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU};
    endfunction

    function automatic logic is_divide(input logic [2:0] op);
        return op inside {MDU_DIV, MDU_DIVU};
    endfunction

endpackage

// File: rtl/mdu_hilo_if.sv
// E-stage request / HI-LO result bundle between the pipeline and the MDU.
interface mdu_hilo_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cancel;
    logic             md_instr_D;
    logic             busy;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             stall;

    modport master (
        output start, op, a, b, cancel, md_instr_D,
        input  busy, hi, lo, stall
    );

    modport slave (
        input  start, op, a, b, cancel, md_instr_D,
        output busy, hi, lo, stall
    );
endinterface

// File: rtl/mdu_arith.sv
// Combinational MULT/MULTU/DIV/DIVU result generator, including the
// divide-by-zero and signed-overflow results.
module mdu_arith
    import mdu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    logic signed [WIDTH-1:0]   a_s, b_s, b_safe_s, q_s, r_s;
    logic signed [2*WIDTH-1:0] a_x, b_x, prod_s;
    logic [2*WIDTH-1:0]        prod_u;
    logic [WIDTH-1:0]          b_safe_u, q_u, r_u;
    logic                      div_zero, div_ovf;

    assign a_s    = $signed(a);
    assign b_s    = $signed(b);
    assign a_x    = (2*WIDTH)'(a_s);
    assign b_x    = (2*WIDTH)'(b_s);
    assign prod_s = a_x * b_x;
    assign prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

    assign div_zero = (b == '0);
    assign div_ovf  = (a == MIN_VAL) && (b == '1);

    // Special cases get a harmless divisor so the real divider never sees them.
    assign b_safe_s = (div_zero || div_ovf) ? WIDTH'(1) : b_s;
    assign b_safe_u = div_zero ? WIDTH'(1) : b;
    assign q_s      = a_s / b_safe_s;
    assign r_s      = a_s % b_safe_s;
    assign q_u      = a / b_safe_u;
    assign r_u      = a % b_safe_u;

    always_comb begin
        res_hi = '0;
        res_lo = '0;
        case (op)
            MDU_MULT:  {res_hi, res_lo} = prod_s;
            MDU_MULTU: {res_hi, res_lo} = prod_u;
            MDU_DIV: begin
                if (div_zero) begin
                    res_hi = a;
                    res_lo = '1;
                end else if (div_ovf) begin
                    res_hi = '0;
                    res_lo = MIN_VAL;
                end else begin
                    res_hi = r_s;
                    res_lo = q_s;
                end
            end
            MDU_DIVU: begin
                if (div_zero) begin
                    res_hi = a;
                    res_lo = '1;
                end else begin
                    res_hi = r_u;
                    res_lo = q_u;
                end
            end
            default: begin
                res_hi = '0;
                res_lo = '0;
            end
        endcase
    end

endmodule

// File: rtl/mdu_hilo.sv
// Multiply/divide unit with HI/LO: fixed-latency busy counter, pending result
// registers, HI/LO commit and the D-stage stall request.
module mdu_hilo
    import mdu_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input logic       clk,
    input logic       reset,
    mdu_hilo_if.slave bus
);
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
    logic [WIDTH-1:0] arith_hi, arith_lo;

    mdu_arith #(.WIDTH(WIDTH)) u_arith (
        .op     (bus.op),
        .a      (bus.a),
        .b      (bus.b),
        .res_hi (arith_hi),
        .res_lo (arith_lo)
    );

    // A nonzero counter is the RUN state; there is no separate state register.
    always_comb begin
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        if (cnt_q != '0) begin
            if (bus.cancel) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_W'(1)) begin
                cnt_d = '0;
                hi_d  = pend_hi_q;
                lo_d  = pend_lo_q;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end else if (bus.start && !bus.cancel) begin
            if (is_multicycle(bus.op)) begin
                pend_hi_d = arith_hi;
                pend_lo_d = arith_lo;
                cnt_d     = is_divide(bus.op) ? DIV_LOAD : MULT_LOAD;
            end else if (bus.op == MDU_MTHI) begin
                hi_d = bus.a;
            end else if (bus.op == MDU_MTLO) begin
                lo_d = bus.a;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
        end
    end

    assign bus.busy  = (cnt_q != '0);
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;
    // Holding D until busy falls means HI/LO never need forwarding.
    assign bus.stall = bus.md_instr_D & (bus.busy | (bus.start & is_multicycle(bus.op)));

endmodule

// File: tb/tb_mdu_hilo.sv
// Scoreboard bench for mdu_hilo: directed scenarios plus random ops against
// an arithmetic reference model.
module tb_mdu_hilo;
    import mdu_pkg::*;

    localparam int W  = 32;
    localparam int MC = 5;
    localparam int DC = 10;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mdu_hilo_if #(.WIDTH(W)) bus();

    mdu_hilo #(.WIDTH(W), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic [31:0] cyc;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned cyc       = 0;
    int          n_checks  = 0;
    int          n_pass    = 0;
    int          proto_cnt = 0;
    logic [31:0] m_hi      = '0;
    logic [31:0] m_lo      = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk)
        if (!reset && bus.start && bus.busy && !bus.cancel) proto_cnt <= proto_cnt + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: results derived from sign/magnitude arithmetic on 64-bit ints.
    function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint          sa, sb, ma, mb, q, r, p;
        longint unsigned ua, ub, pu;
        logic [63:0]     res;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        res = '0;
        case (op)
            3'd0: begin p = sa * sb; res = p; end
            3'd1: begin pu = ua * ub; res = pu; end
            3'd2: begin
                if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
                else begin
                    ma = (sa < 0) ? -sa : sa;
                    mb = (sb < 0) ? -sb : sb;
                    q  = ma / mb;
                    if ((sa < 0) != (sb < 0)) q = -q;
                    r   = sa - q * sb;
                    res = {r[31:0], q[31:0]};
                end
            end
            3'd3: begin
                if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
                else begin
                    q   = longint'(ua / ub);
                    r   = longint'(ua % ub);
                    res = {r[31:0], q[31:0]};
                end
            end
            default: res = '0;
        endcase
        return res;
    endfunction

    task automatic monitor();
        logic        pb;
        logic [31:0] ph, pl;
        exp_t        e;
        pb = 1'b0; ph = '0; pl = '0;
        forever begin
            @(negedge clk);
            if (!reset && ((pb && !bus.busy) ||
                           (!pb && !bus.busy && (bus.hi !== ph || bus.lo !== pl)))) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL sb_unexpected: hi=0x%0h lo=0x%0h busy=%0b at cycle %0d, no result expected",
                             bus.hi, bus.lo, bus.busy, cyc);
                end else begin
                    e = sb_q.pop_front();
                    chk("sb_hi", bus.hi, e.hi);
                    chk("sb_lo", bus.lo, e.lo);
                    chk("sb_cycle", cyc, e.cyc);
                end
            end
            pb = bus.busy;
            ph = bus.hi;
            pl = bus.lo;
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 64 && bus.busy; i++) tick();
        chk("idle", bus.busy, 0);
    endtask

    // k < 0: run to completion; otherwise cancel after k further busy cycles.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic md_d, input int k);
        logic [63:0] r;
        int          lat;
        logic        multi;
        exp_t        e;
        int unsigned e0;
        multi = (op <= 3'd3);
        lat   = (op == 3'd2 || op == 3'd3) ? DC : MC;
        if (op == 3'd4 && a == m_hi) a = a ^ 32'd1;
        if (op == 3'd5 && a == m_lo) a = a ^ 32'd1;
        e0 = cyc;
        bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b; bus.md_instr_D = md_d;
        #1;
        chk("stall_issue", bus.stall, md_d && multi);
        if (multi) begin
            if (k < 0) begin
                r     = ref_result(op, a, b);
                e.hi  = r[63:32];
                e.lo  = r[31:0];
                e.cyc = e0 + 1 + lat;
                m_hi  = r[63:32];
                m_lo  = r[31:0];
            end else begin
                e.hi  = m_hi;
                e.lo  = m_lo;
                e.cyc = e0 + 2 + k;
            end
            sb_q.push_back(e);
        end else if (op == 3'd4) begin
            e.hi = a; e.lo = m_lo; e.cyc = e0 + 1; m_hi = a;
            sb_q.push_back(e);
        end else if (op == 3'd5) begin
            e.hi = m_hi; e.lo = a; e.cyc = e0 + 1; m_lo = a;
            sb_q.push_back(e);
        end
        tick();
        bus.start = 1'b0; bus.md_instr_D = 1'b0;
        chk("busy_after_issue", bus.busy, multi);
        if (multi && k < 0) begin
            for (int i = 1; i <= lat; i++) begin
                tick();
                chk("busy_run", bus.busy, i < lat);
            end
        end else if (multi) begin
            repeat (k) tick();
            bus.cancel = 1'b1;
            tick();
            bus.cancel = 1'b0;
            chk("busy_cancel", bus.busy, 0);
        end
        wait_idle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        exp_t        e;
        logic [63:0] r;
        int unsigned e0;
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        int          rk;

        bus.start = 1'b0; bus.op = 3'd0; bus.a = '0; bus.b = '0;
        bus.cancel = 1'b0; bus.md_instr_D = 1'b0;
        fork
            monitor();
        join_none

        // Reset state; stall is purely combinational even under reset.
        #1;
        chk("rst_busy", bus.busy, 0);
        chk("rst_hi", bus.hi, 0);
        chk("rst_lo", bus.lo, 0);
        bus.md_instr_D = 1'b1; bus.start = 1'b1; bus.op = 3'd2;
        #1;
        chk("rst_stall_on", bus.stall, 1);
        bus.md_instr_D = 1'b0;
        #1;
        chk("rst_stall_off", bus.stall, 0);
        bus.start = 1'b0;
        tick(); tick();
        reset = 1'b0;
        tick();

        issue(3'd0, 32'hFFFF_FFFE, 32'd3, 1'b0, -1);
        chk("mult_hi", bus.hi, 32'hFFFF_FFFF);
        chk("mult_lo", bus.lo, 32'hFFFF_FFFA);

        issue(3'd3, 32'd7, 32'd0, 1'b0, -1);
        chk("divu0_hi", bus.hi, 32'd7);
        chk("divu0_lo", bus.lo, 32'hFFFF_FFFF);

        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, -1);
        chk("divovf_hi", bus.hi, 32'd0);
        chk("divovf_lo", bus.lo, 32'h8000_0000);

        // DIV -7/2 with a D-stage MD instruction waiting behind it.
        e0 = cyc;
        bus.start = 1'b1; bus.op = 3'd2; bus.a = 32'hFFFF_FFF9; bus.b = 32'd2;
        bus.md_instr_D = 1'b1;
        r = ref_result(3'd2, 32'hFFFF_FFF9, 32'd2);
        e.hi = r[63:32]; e.lo = r[31:0]; e.cyc = e0 + 1 + DC;
        sb_q.push_back(e);
        m_hi = r[63:32]; m_lo = r[31:0];
        #1;
        chk("div_stall_start", bus.stall, 1);
        tick();
        bus.start = 1'b0;
        for (int i = 0; i <= DC; i++) begin
            chk("div_stall_run", bus.stall, i < DC);
            if (i < DC) tick();
        end
        bus.md_instr_D = 1'b0;
        chk("div_hi", bus.hi, 32'hFFFF_FFFF);
        chk("div_lo", bus.lo, 32'hFFFF_FFFD);

        issue(3'd5, 32'h0000_1234, 32'd0, 1'b0, -1);
        chk("mtlo_lo", bus.lo, 32'h0000_1234);

        // A start arriving mid-run must not disturb the op in flight.
        e0 = cyc;
        bus.start = 1'b1; bus.op = 3'd0; bus.a = 32'd100; bus.b = 32'd200;
        r = ref_result(3'd0, 32'd100, 32'd200);
        e.hi = r[63:32]; e.lo = r[31:0]; e.cyc = e0 + 1 + MC;
        sb_q.push_back(e);
        m_hi = r[63:32]; m_lo = r[31:0];
        tick();
        bus.start = 1'b0;
        tick(); tick();
        bus.start = 1'b1; bus.op = 3'd2; bus.a = 32'd5; bus.b = 32'd7;
        tick();
        bus.start = 1'b0;
        repeat (MC - 3) tick();
        chk("intrude_busy", bus.busy, 0);
        chk("intrude_lo", bus.lo, 32'd20000);

        issue(3'd4, 32'h0000_00AA, 32'd0, 1'b0, -1);
        issue(3'd5, 32'h0000_00BB, 32'd0, 1'b0, -1);
        issue(3'd0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 2);
        chk("cancel_hi", bus.hi, 32'h0000_00AA);
        chk("cancel_lo", bus.lo, 32'h0000_00BB);

        bus.start = 1'b1; bus.op = 3'd4; bus.a = 32'h5555; bus.cancel = 1'b1;
        tick();
        bus.start = 1'b0; bus.cancel = 1'b0;
        tick();
        chk("mthi_cancel_hi", bus.hi, 32'h0000_00AA);

        // Asynchronous reset in the middle of a DIV.
        bus.start = 1'b1; bus.op = 3'd2; bus.a = 32'd100; bus.b = 32'd7;
        tick();
        bus.start = 1'b0;
        tick(); tick(); tick();
        #2;
        reset = 1'b1;
        #1;
        chk("arst_busy", bus.busy, 0);
        chk("arst_hi", bus.hi, 0);
        chk("arst_lo", bus.lo, 0);
        m_hi = '0; m_lo = '0;
        tick();
        reset = 1'b0;
        tick();
        issue(3'd1, 32'hFFFF_FFFF, 32'd2, 1'b1, -1);
        chk("multu_hi", bus.hi, 32'd1);
        chk("multu_lo", bus.lo, 32'hFFFF_FFFE);

        for (int n = 0; n < 80; n++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 9))
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = 32'($urandom_range(1, 9));
                default: ;
            endcase
            rk = -1;
            if (rop <= 3'd3 && $urandom_range(0, 5) == 0)
                rk = $urandom_range(0, ((rop >= 3'd2) ? DC : MC) - 2);
            issue(rop, ra, rb, 1'($urandom_range(0, 1)), rk);
        end

        tick(); tick();
        chk("sb_drained", sb_q.size(), 0);
        chk("protocol_starts", proto_cnt, 1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
